// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, word-aligned requests with byte enables.
// Define LSU_TIMEOUT_EN to abort loads whose read data never arrives.
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Handshake: a request is taken in any cycle where req_valid and req_ready are both
  // high at the rising edge; req_ready is high only in IDLE. The memory side holds
  // mem_req and its fields until a cycle with mem_gnt; resp_valid is never back-pressured.

  logic [1:0]        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;

  logic        accept;
  logic        bad_access;
  logic        timeout_hit;
  logic [31:0] lane;
  logic [31:0] load_ext;

  assign accept     = req_valid & req_ready_q;
  assign bad_access = (req_size == 2'b11)
                    | ((req_size == 2'b01) & req_addr[0])
                    | ((req_size == 2'b10) & (|req_addr[1:0]));

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter sits at zero outside WAIT_R, so it is already clear on entry.
  assign cnt_d       = ((state_q == S_WAIT_R) && !mem_rvalid) ? cnt_q + 1'b1 : '0;
  assign timeout_hit = (state_q == S_WAIT_R) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          size_d = req_size;
          uns_d  = req_unsigned;
          off_d  = req_addr[1:0];
          if (bad_access) begin
            state_d    = S_RESP;
            resp_err_d = 1'b1;
          end else begin
            state_d    = S_REQ;
            mem_we_d   = req_we;
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            case (req_size)
              2'b00: begin
                mem_be_d    = 4'b0001 << req_addr[1:0];
                mem_wdata_d = {4{req_wdata[7:0]}};
              end
              2'b01: begin
                mem_be_d    = 4'b0011 << req_addr[1:0];
                mem_wdata_d = {2{req_wdata[15:0]}};
              end
              default: begin
                mem_be_d    = 4'b1111;
                mem_wdata_d = req_wdata;
              end
            endcase
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = mem_we_q ? S_RESP : S_WAIT_R;
      end
      S_WAIT_R: begin
        if (mem_rvalid) begin
          state_d      = S_RESP;
          resp_rdata_d = load_ext;
        end else if (timeout_hit) begin
          state_d    = S_RESP;
          resp_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered straight from the next state.
    req_ready_d  = (state_d == S_IDLE);
    mem_req_d    = (state_d == S_REQ);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      off_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_be      = mem_be_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized transactions against a
// byte-level reference model, reset-in-flight and (with LSU_TIMEOUT_EN) load timeout.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rv_dly;     // 0 on a load: read data never returned
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int gd, input int rd, input logic [31:0] rdata,
                              input logic [3:0] ebe, input logic [31:0] ema,
                              input logic [31:0] ewd, input logic eerr,
                              input logic [31:0] erd);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.gnt_dly = gd; v.rv_dly = rd; v.rdata = rdata;
    v.exp_be = ebe; v.exp_maddr = ema; v.exp_wdata = ewd; v.exp_err = eerr; v.exp_rdata = erd;
    return v;
  endfunction

  // Reference model: works in whole bytes and plain integer arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    int     off, nb;
    longint val, span;
    r   = v;
    off = int'(v.addr % 4);
    nb  = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    r.exp_err   = (v.size == 2'd3) || ((v.addr % nb) != 0);
    r.exp_maddr = v.addr - off;
    r.exp_be    = 4'd0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + nb) r.exp_be[i] = 1'b1;
    if (nb == 1)      r.exp_wdata = (v.wdata % 256) * 32'h0101_0101;
    else if (nb == 2) r.exp_wdata = (v.wdata % 65536) * 32'h0001_0001;
    else              r.exp_wdata = v.wdata;
    r.exp_rdata = 32'd0;
    if (!r.exp_err && !v.we) begin
      if (v.rv_dly == 0) begin
        r.exp_err = 1'b1;
      end else begin
        span = longint'(1) << (8 * nb);
        val  = (longint'(v.rdata) / (longint'(1) << (8 * off))) % span;
        if (!v.uns && nb < 4 && val >= span / 2) val = val - span;
        r.exp_rdata = 32'(val);
      end
    end
    return r;
  endfunction

  // Driver: issues one request and plays the memory; checks latency and fields.
  task automatic run_txn(input vec_t v);
    int   cyc, req_cyc, g, resp_cyc, exp_cyc;
    logic got, stable_ok, ready_ok, r_err;
    logic [31:0] r_data, a0, w0;
    logic [3:0]  be0;
    logic        we0;
    exp_q.push_back(v.exp_rdata);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    chk("ready_at_issue", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom_range(0, 3)); req_we = 1'($urandom_range(0, 1));
    cyc = 1; req_cyc = 0; g = -1; got = 1'b0; stable_ok = 1'b1; ready_ok = 1'b1;
    resp_cyc = 0; r_err = 1'b0; r_data = 32'd0; a0 = '0; w0 = '0; be0 = '0; we0 = 1'b0;
    while (!got && cyc < 80) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (resp_valid) begin
        got = 1'b1; resp_cyc = cyc; r_err = resp_err; r_data = resp_rdata;
      end else begin
        if (req_ready) ready_ok = 1'b0;
        if (mem_req) begin
          if (req_cyc == 0) begin
            a0 = mem_addr; w0 = mem_wdata; be0 = mem_be; we0 = mem_we;
          end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_be !== be0 || mem_we !== we0) begin
            stable_ok = 1'b0;
          end
          req_cyc++;
          if (req_cyc > v.gnt_dly) begin
            mem_gnt = 1'b1; g = cyc;
          end else begin
            mem_rvalid = 1'($urandom_range(0, 1));
          end
        end else if (g >= 0 && !v.we && v.rv_dly > 0 && cyc == g + v.rv_dly) begin
          mem_rvalid = 1'b1; mem_rdata = v.rdata;
        end
        @(negedge clk);
        cyc++;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_timeout: got no resp_valid in 80 cycles, required one");
      void'(exp_q.pop_front());
      return;
    end
    if (v.exp_err && (v.we || v.rv_dly != 0 || v.size == 2'd3 || (v.addr % 4) != 0 && model(v).exp_err && v.exp_rdata == 0 && req_cyc == 0))
      exp_cyc = 1;
    else
      exp_cyc = 1;
    if (model(v).exp_err && !(v.size != 2'd3 && !v.we && v.rv_dly == 0 && (v.addr % ((v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4)) == 0))
      exp_cyc = 1;
    else if (v.we)
      exp_cyc = 1 + v.gnt_dly + 1;
    else if (v.rv_dly == 0)
      exp_cyc = 1 + v.gnt_dly + TO + 1;
    else
      exp_cyc = 1 + v.gnt_dly + v.rv_dly + 1;
    chk("resp_cycle", resp_cyc, exp_cyc);
    chk("resp_err", {31'd0, r_err}, {31'd0, v.exp_err});
    chk("resp_rdata", r_data, exp_q.pop_front());
    chk("ready_low_busy", {31'd0, ready_ok}, 32'd1);
    chk("mem_req_cycles", req_cyc, (exp_cyc == 1) ? 0 : v.gnt_dly + 1);
    if (exp_cyc != 1) begin
      chk("mem_be", {28'd0, be0}, {28'd0, v.exp_be});
      chk("mem_addr", a0, v.exp_maddr);
      chk("mem_we", {31'd0, we0}, {31'd0, v.we});
      chk("mem_fields_stable", {31'd0, stable_ok}, 32'd1);
      if (v.we) chk("mem_wdata", w0, v.exp_wdata);
    end
    @(negedge clk);
    chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  vec_t tbl[12];
  vec_t rv;
  int   pulses;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_outputs", {resp_valid, resp_err, mem_req, mem_we, mem_be, 24'd0}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    //           we    sz     uns   addr   wdata         gd rd rdata          be       maddr  wdata         err   rdata
    tbl[0]  = mk(1'b1, 2'd0, 1'b0, 32'd8,  32'h0000_00AA, 0, 0, 32'd0,         4'b0001, 32'd8,  32'hAAAA_AAAA, 1'b0, 32'd0);
    tbl[1]  = mk(1'b1, 2'd1, 1'b0, 32'd14, 32'h0000_BBBB, 0, 0, 32'd0,         4'b1100, 32'd12, 32'hBBBB_BBBB, 1'b0, 32'd0);
    tbl[2]  = mk(1'b0, 2'd1, 1'b1, 32'd14, 32'd0,         0, 1, 32'hBBBB_0000, 4'b1100, 32'd12, 32'd0,         1'b0, 32'h0000_BBBB);
    tbl[3]  = mk(1'b0, 2'd0, 1'b0, 32'd9,  32'd0,         0, 1, 32'h1234_80FF, 4'b0010, 32'd8,  32'd0,         1'b0, 32'hFFFF_FF80);
    tbl[4]  = mk(1'b0, 2'd0, 1'b1, 32'd9,  32'd0,         0, 1, 32'h1234_80FF, 4'b0010, 32'd8,  32'd0,         1'b0, 32'h0000_0080);
    tbl[5]  = mk(1'b0, 2'd2, 1'b0, 32'd16, 32'd0,         3, 2, 32'hDEAD_BEEF, 4'b1111, 32'd16, 32'd0,         1'b0, 32'hDEAD_BEEF);
    tbl[6]  = mk(1'b0, 2'd2, 1'b0, 32'd18, 32'd0,         0, 1, 32'h5555_5555, 4'b0000, 32'd0,  32'd0,         1'b1, 32'd0);
    tbl[7]  = mk(1'b1, 2'd1, 1'b0, 32'd13, 32'h0000_1234, 0, 0, 32'd0,         4'b0000, 32'd0,  32'd0,         1'b1, 32'd0);
    tbl[8]  = mk(1'b0, 2'd3, 1'b0, 32'd4,  32'd0,         0, 1, 32'h1111_1111, 4'b0000, 32'd0,  32'd0,         1'b1, 32'd0);
    tbl[9]  = mk(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, 1, 0, 32'd0,         4'b1111, 32'h20, 32'h1234_5678, 1'b0, 32'd0);
    tbl[10] = mk(1'b0, 2'd1, 1'b0, 32'd2,  32'd0,         2, 3, 32'h8001_7FFF, 4'b1100, 32'd0,  32'd0,         1'b0, 32'hFFFF_8001);
    tbl[11] = mk(1'b1, 2'd0, 1'b0, 32'h33, 32'hFFFF_FF5C, 0, 0, 32'd0,         4'b1000, 32'h30, 32'h5C5C_5C5C, 1'b0, 32'd0);
    for (int i = 0; i < 12; i++) run_txn(tbl[i]);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      rv = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3), $urandom,
              4'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      if ($urandom_range(0, 3) != 0) rv.addr[1:0] = rv.addr[1:0] & ((rv.size == 2'd2) ? 2'b00 : (rv.size == 2'd1) ? 2'b10 : 2'b11);
      run_txn(model(rv));
    end

    // Reset while a load waits for read data; late rvalid must be ignored.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_mem_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstmid_in_wait", {30'd0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid_mem_req_low", {31'd0, mem_req}, 32'd0);
    pulses = 0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    mem_rvalid = 1'b0;
    chk("rstmid_no_resp", pulses, 0);
    chk("rstmid_state_idle", {30'd0, dbg_state}, 32'd0);

    // Back-to-back after reset recovery.
    run_txn(model(mk(1'b0, 2'd0, 1'b0, 32'h47, 32'd0, 0, 1, 32'h7F00_0000, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0)));
`ifdef LSU_TIMEOUT_EN
    run_txn(model(mk(1'b0, 2'd2, 1'b0, 32'h50, 32'd0, 0, 0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0)));
    run_txn(model(mk(1'b0, 2'd1, 1'b1, 32'h52, 32'd0, 2, 0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0)));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
